// File: rtl/num_roam_multi.sv
// Roaming-digit driver for a multiplexed common-anode seven-segment bank.
// A single lit digit walks across the bank at a divided tick rate. Its hex
// value steps up or down each time the digit wraps past the end of the bank.
// Optional macro NUM_ROAM_STEP_EN adds a synchronised pushbutton input, `step`,
// whose rising edges act as extra roam ticks.
module num_roam_multi #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned DIV_COUNT  = 10000000,
  parameter int unsigned POS_W      = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [3:0]            load_val,
`ifdef NUM_ROAM_STEP_EN
  input  logic                  step,
`endif
  output logic [NUM_DIGITS-1:0] digit_sel_n,
  output logic [7:0]            seg_n,
  output logic [3:0]            value,
  output logic                  wrap
);

  localparam int unsigned CNT_W = $clog2(DIV_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_COUNT - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_RST = {1'b0, {(NUM_DIGITS - 1){1'b1}}};
  localparam logic [7:0] SEG_RST = 8'b0000_0011;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic [3:0]            value_q, value_d;
  logic                  wrap_q, wrap_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [7:0]            seg_q, seg_d;
  logic                  div_tick;
  logic                  tick;

  // Active-high {a,b,c,d,e,f,g,dp}; dp never lit.
  function automatic logic [7:0] hex_seg(input logic [3:0] v);
    logic [7:0] s;
    unique case (v)
      4'h0: s = 8'b1111_1100;
      4'h1: s = 8'b0110_0000;
      4'h2: s = 8'b1101_1010;
      4'h3: s = 8'b1111_0010;
      4'h4: s = 8'b0110_0110;
      4'h5: s = 8'b1011_0110;
      4'h6: s = 8'b1011_1110;
      4'h7: s = 8'b1110_0100;
      4'h8: s = 8'b1111_1110;
      4'h9: s = 8'b1111_0110;
      4'hA: s = 8'b1110_1110;
      4'hB: s = 8'b0011_1110;
      4'hC: s = 8'b1001_1100;
      4'hD: s = 8'b0111_1010;
      4'hE: s = 8'b1001_1110;
      4'hF: s = 8'b1000_1110;
    endcase
    return s;
  endfunction

  assign div_tick = (cnt_q == CNT_MAX);

`ifdef NUM_ROAM_STEP_EN
  logic step_meta_q, step_sync_q, step_prev_q;

  // Two-flop synchroniser plus one delay flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_meta_q <= 1'b0;
      step_sync_q <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      step_meta_q <= step;
      step_sync_q <= step_meta_q;
      step_prev_q <= step_sync_q;
    end
  end

  // A step edge coinciding with a divider tick still counts as one tick.
  assign tick = div_tick | (step_sync_q & ~step_prev_q);
`else
  assign tick = div_tick;
`endif

  // Next-state: free-running divider, then load > (tick & en) > hold.
  always_comb begin
    cnt_d   = div_tick ? '0 : cnt_q + CNT_W'(1);
    pos_d   = pos_q;
    value_d = value_q;
    wrap_d  = 1'b0;
    if (load) begin
      value_d = load_val;
      pos_d   = POS_LAST;
    end else if (tick && en) begin
      if (up_down) begin
        if (pos_q == '0) begin
          pos_d   = POS_LAST;
          value_d = value_q + 4'd1;
          wrap_d  = 1'b1;
        end else begin
          pos_d = pos_q - POS_W'(1);
        end
      end else begin
        if (pos_q == POS_LAST) begin
          pos_d   = '0;
          value_d = value_q - 4'd1;
          wrap_d  = 1'b1;
        end else begin
          pos_d = pos_q + POS_W'(1);
        end
      end
    end
    sel_d        = '1;
    sel_d[pos_d] = 1'b0;
    seg_d        = ~hex_seg(value_d);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pos_q   <= POS_LAST;
      value_q <= 4'd0;
      wrap_q  <= 1'b0;
      sel_q   <= SEL_RST;
      seg_q   <= SEG_RST;
    end else begin
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      value_q <= value_d;
      wrap_q  <= wrap_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign digit_sel_n = sel_q;
  assign seg_n       = seg_q;
  assign value       = value_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_num_roam_multi.sv
// Scoreboard bench for num_roam_multi with NUM_DIGITS=4 and DIV_COUNT=4.
// Expected output changes are queued with the cycle they must appear in.
// A monitor pops one entry each time the registered outputs change.
module tb_num_roam_multi;

  localparam int ND = 4;
  localparam int DC = 4;
  localparam logic [7:0] SEG_TAB [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE4,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  typedef struct {
    int         cyc;
    logic [3:0] sel;
    logic [7:0] seg;
    logic [3:0] val;
    logic       wrap;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          up_down = 1'b1;
  logic          load = 1'b0;
  logic [3:0]    load_val = 4'd0;
`ifdef NUM_ROAM_STEP_EN
  logic          step = 1'b0;
`endif
  logic [ND-1:0] digit_sel_n;
  logic [7:0]    seg_n;
  logic [3:0]    value;
  logic          wrap;

  int   cyc;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t q[$];

  num_roam_multi #(
    .NUM_DIGITS(ND),
    .DIV_COUNT (DC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .up_down    (up_down),
    .load       (load),
    .load_val   (load_val),
`ifdef NUM_ROAM_STEP_EN
    .step       (step),
`endif
    .digit_sel_n(digit_sel_n),
    .seg_n      (seg_n),
    .value      (value),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  // Cycle stamp: posedges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic push(input int c, input int pos, input int v, input logic w);
    exp_t e;
    e.cyc       = c;
    e.sel       = 4'hF;
    e.sel[pos]  = 1'b0;
    e.val       = 4'(v);
    e.seg       = ~SEG_TAB[v];
    e.wrap      = w;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // Monitor: every change of the registered outputs consumes one expected entry.
  initial begin
    logic [16:0] prev, cur;
    exp_t e;
    forever begin
      @(negedge clk);
      cur = {digit_sel_n, seg_n, value, wrap};
      if (rst_n && cur !== prev) begin
        n_vec++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change cyc=%0d got sel=%b seg=%h val=%h wrap=%b",
                   cyc, digit_sel_n, seg_n, value, wrap);
        end else begin
          e = q.pop_front();
          if (cyc != e.cyc || digit_sel_n !== e.sel || seg_n !== e.seg ||
              value !== e.val || wrap !== e.wrap) begin
            n_bad++;
            $display("FAIL roam_step: got cyc=%0d sel=%b seg=%h val=%h wrap=%b, expected cyc=%0d sel=%b seg=%h val=%h wrap=%b",
                     cyc, digit_sel_n, seg_n, value, wrap,
                     e.cyc, e.sel, e.seg, e.val, e.wrap);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    en      = 1'b1;
    up_down = 1'b1;
    #22;
    chk("reset_sel", 16'(digit_sel_n), 16'b0111);
    chk("reset_seg", 16'(seg_n), 16'(8'b0000_0011));
    chk("reset_value", 16'(value), 16'd0);
    chk("reset_wrap", 16'(wrap), 16'd0);

    // Roam up for 64 ticks: value runs 0..F and wraps back to 0.
    for (int t = 1; t <= 64; t++) begin
      push(4 * t, (3 - (t % 4) + 4) % 4, (t / 4) % 16, (t % 4) == 0);
      if (t % 4 == 0) push(4 * t + 1, 3, (t / 4) % 16, 1'b0);
    end
    push(260, 2, 0, 1'b0);
    push(264, 1, 0, 1'b0);
    // Direction flipped at pos 1: continue from there, no value change.
    push(268, 2, 0, 1'b0);
    push(272, 3, 0, 1'b0);
    // en low across ticks 276/280/284: nothing moves.
    push(288, 0, 15, 1'b1);
    push(289, 0, 15, 1'b0);
    push(292, 1, 15, 1'b0);
    push(296, 2, 15, 1'b0);
    push(300, 3, 15, 1'b0);
    // Load beats the wrap tick at 304.
    push(304, 3, 9, 1'b0);
    push(308, 0, 8, 1'b1);
    push(309, 0, 8, 1'b0);
    push(312, 1, 8, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    wait_cyc(265);
    up_down = 1'b0;
    wait_cyc(272);
    en = 1'b0;
    wait_cyc(285);
    en = 1'b1;
    wait_cyc(303);
    load     = 1'b1;
    load_val = 4'd9;
    wait_cyc(304);
    load = 1'b0;
    wait_cyc(313);

    // Asynchronous reset mid-roam, checked before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sel", 16'(digit_sel_n), 16'b0111);
    chk("async_rst_seg", 16'(seg_n), 16'(8'b0000_0011));
    chk("async_rst_value", 16'(value), 16'd0);
    chk("async_rst_wrap", 16'(wrap), 16'd0);
    chk("leftover_expected", 16'(q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
